// File: rtl/hazard_stall_ctrl.sv
// D-stage hazard detection and stall control for a 5-stage MIPS pipeline.
// Tracks E/M/W writers, emits stall, D-stage forward selects and a stall counter.
module hazard_stall_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        tuse_rs,
   input  logic [1:0]        tuse_rt,
   input  logic [1:0]        tnew_d,
   input  logic [REG_AW-1:0] rs_d,
   input  logic [REG_AW-1:0] rt_d,
   input  logic [REG_AW-1:0] a3_d,
   output logic              stall,
   output logic              pc_en,
   output logic              fd_en,
   output logic              de_clr,
   output logic [1:0]        fwd_rs,
   output logic [1:0]        fwd_rt,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic [REG_AW-1:0] a3_e;
   logic [REG_AW-1:0] a3_m;
   logic [REG_AW-1:0] a3_w;
   logic [1:0]        tnew_e;
   logic [1:0]        tnew_m;
   logic              stall_rs;
   logic              stall_rt;

   // Youngest matching writer decides; result is {stall, fwd}.
   function automatic logic [2:0] resolve(
      input logic [REG_AW-1:0] src,
      input logic [1:0]        tuse,
      input logic [REG_AW-1:0] ae,
      input logic [1:0]        te,
      input logic [REG_AW-1:0] am,
      input logic [1:0]        tm,
      input logic [REG_AW-1:0] aw
   );
      logic [2:0] res;
      res = 3'b000;
      if (src != '0) begin
         unique case (1'b1)
            (src == ae): res = (te > tuse) ? 3'b100 : 3'b001;
            (src != ae) && (src == am):
               res = (tm > tuse) ? 3'b100 : 3'b010;
            (src != ae) && (src != am) && (src == aw):
               res = 3'b011;
            default: res = 3'b000;
         endcase
      end
      return res;
   endfunction

   // Hazard resolution for both source operands.
   always_comb begin
      logic [2:0] r_rs;
      logic [2:0] r_rt;
      r_rs = resolve(rs_d, tuse_rs, a3_e, tnew_e, a3_m, tnew_m, a3_w);
      r_rt = resolve(rt_d, tuse_rt, a3_e, tnew_e, a3_m, tnew_m, a3_w);
      stall_rs = r_rs[2];
      stall_rt = r_rt[2];
      fwd_rs   = r_rs[1:0];
      fwd_rt   = r_rt[1:0];
      stall    = stall_rs | stall_rt;
      pc_en    = ~stall;
      fd_en    = ~stall;
      de_clr   = stall;
   end

   // Writer slots advance each edge; a stall injects a bubble into E.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a3_e   <= '0;
         tnew_e <= '0;
         a3_m   <= '0;
         tnew_m <= '0;
         a3_w   <= '0;
      end else begin
         a3_w   <= a3_m;
         a3_m   <= a3_e;
         tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
         if (stall) begin
            a3_e   <= '0;
            tnew_e <= '0;
         end else begin
            a3_e   <= a3_d;
            tnew_e <= tnew_d;
         end
      end
   end

   // Saturating count of stalled cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed pipeline scenarios plus random
// instruction streams checked against an in-flight-writer age model.
module tb_hazard_stall_ctrl;

   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    tuse_rs;
   logic [1:0]    tuse_rt;
   logic [1:0]    tnew_d;
   logic [AW-1:0] rs_d;
   logic [AW-1:0] rt_d;
   logic [AW-1:0] a3_d;
   logic          stall;
   logic          pc_en;
   logic          fd_en;
   logic          de_clr;
   logic [1:0]    fwd_rs;
   logic [1:0]    fwd_rt;
   logic [CW-1:0] stall_cnt;

   hazard_stall_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .tnew_d(tnew_d),
      .rs_d(rs_d), .rt_d(rt_d), .a3_d(a3_d),
      .stall(stall), .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
      .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int tnew;
      int age;
   } wr_t;

   wr_t q[$];
   int  cnt_m;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cmax = (1 << CW) - 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Writer age 0/1/2 = E/M/W; cycles until its result exists = tnew - age.
   task automatic lookup(input int a, input int tu,
                         output int st, output int fw);
      int best;
      int rem;
      best = -1;
      rem  = 0;
      st   = 0;
      fw   = 0;
      if (a != 0) begin
         foreach (q[i]) begin
            if (q[i].addr == a && (best < 0 || q[i].age < q[best].age))
               best = i;
         end
         if (best >= 0) begin
            rem = q[best].tnew - q[best].age;
            if (rem < 0) rem = 0;
            st = (rem > tu) ? 1 : 0;
            fw = st ? 0 : q[best].age + 1;
         end
      end
   endtask

   task automatic step(input int tr, input int tt, input int tn,
                       input int rs, input int rt, input int a3);
      int  s1;
      int  f1;
      int  s2;
      int  f2;
      int  s;
      wr_t nq[$];
      wr_t e;
      @(negedge clk);
      tuse_rs = 2'(tr);
      tuse_rt = 2'(tt);
      tnew_d  = 2'(tn);
      rs_d    = AW'(rs);
      rt_d    = AW'(rt);
      a3_d    = AW'(a3);
      #1;
      lookup(rs, tr, s1, f1);
      lookup(rt, tt, s2, f2);
      s = s1 | s2;
      chk("stall", 32'(stall), 32'(s));
      chk("pc_en", 32'(pc_en), 32'(1 - s));
      chk("fd_en", 32'(fd_en), 32'(1 - s));
      chk("de_clr", 32'(de_clr), 32'(s));
      chk("fwd_rs", 32'(fwd_rs), 32'(f1));
      chk("fwd_rt", 32'(fwd_rt), 32'(f2));
      chk("stall_cnt", 32'(stall_cnt), 32'(cnt_m));
      if (reset_n) begin
         foreach (q[i]) begin
            if (q[i].age < 2) begin
               e = q[i];
               e.age++;
               nq.push_back(e);
            end
         end
         if (s == 0 && a3 != 0) begin
            e.addr = a3;
            e.tnew = tn;
            e.age  = 0;
            nq.push_back(e);
         end
         q = nq;
         if (s != 0 && cnt_m < cmax) cnt_m++;
      end
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_pc_en"}, 32'(pc_en), 32'd1);
      chk({tag, "_fd_en"}, 32'(fd_en), 32'd1);
      chk({tag, "_de_clr"}, 32'(de_clr), 32'd0);
      chk({tag, "_fwd_rs"}, 32'(fwd_rs), 32'd0);
      chk({tag, "_fwd_rt"}, 32'(fwd_rt), 32'd0);
      chk({tag, "_cnt"}, 32'(stall_cnt), 32'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      q.delete();
      cnt_m = 0;
      check_reset_outs("rst");
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      tuse_rs = 2'd3;
      tuse_rt = 2'd3;
      tnew_d  = 2'd0;
      rs_d    = '0;
      rt_d    = '0;
      a3_d    = '0;
      cnt_m   = 0;
      #2;
      do_reset();

      // No writers at all: never stalls
      for (int i = 0; i < 6; i++) begin
         step(i % 4, (i + 1) % 4, i % 3, i + 1, i + 2, 0);
         chk("t1_stall", 32'(stall), 32'd0);
      end
      chk("t1_cnt", 32'(stall_cnt), 32'd0);

      // lw then dependent ALU op: one stall, then M forward
      do_reset();
      step(3, 3, 2, 0, 0, 8);
      step(1, 3, 0, 8, 0, 9);
      chk("t2_stall1", 32'(stall), 32'd1);
      chk("t2_declr1", 32'(de_clr), 32'd1);
      step(1, 3, 0, 8, 0, 9);
      chk("t2_stall2", 32'(stall), 32'd0);
      chk("t2_fwd", 32'(fwd_rs), 32'd2);
      chk("t2_cnt", 32'(stall_cnt), 32'd1);

      // lw then beq: two stalls, then W forward
      do_reset();
      step(3, 3, 2, 0, 0, 8);
      step(0, 3, 0, 8, 0, 0);
      chk("t3_stall1", 32'(stall), 32'd1);
      step(0, 3, 0, 8, 0, 0);
      chk("t3_stall2", 32'(stall), 32'd1);
      step(0, 3, 0, 8, 0, 0);
      chk("t3_stall3", 32'(stall), 32'd0);
      chk("t3_fwd", 32'(fwd_rs), 32'd3);
      chk("t3_cnt", 32'(stall_cnt), 32'd2);

      // ori then sw reading it late: E forward, no stall
      do_reset();
      step(3, 3, 1, 0, 0, 9);
      step(3, 2, 0, 0, 9, 0);
      chk("t4_stall", 32'(stall), 32'd0);
      chk("t4_fwd", 32'(fwd_rt), 32'd1);

      // Register 0 never creates a dependency
      step(3, 3, 2, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("t5_stall", 32'(stall), 32'd0);
      chk("t5_fwd", 32'(fwd_rs), 32'd0);

      // rs == rt both hazarding, identical selects
      step(3, 3, 2, 0, 0, 7);
      step(1, 1, 0, 7, 7, 0);
      chk("t5b_stall", 32'(stall), 32'd1);
      step(1, 1, 0, 7, 7, 0);
      chk("t5b_same", 32'(fwd_rt), 32'(fwd_rs));
      chk("t5b_fwd", 32'(fwd_rs), 32'd2);

      // Counter saturation, then reset while stalled
      do_reset();
      for (int g = 0; g < 12; g++) begin
         step(3, 3, 2, 0, 0, 5);
         for (int k = 0; k < 3; k++) step(0, 3, 0, 5, 0, 0);
      end
      chk("t6_sat", 32'(stall_cnt), 32'(cmax));
      step(3, 3, 2, 0, 0, 5);
      step(0, 3, 0, 5, 0, 0);
      chk("t6_pre", 32'(stall), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      q.delete();
      cnt_m = 0;
      check_reset_outs("t6_mid");
      @(negedge clk);
      reset_n = 1'b1;

      // Random instruction streams over a small register set
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
